// File: rtl/pipe_csadd.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment resolved per stage, valid/ready flow.
// Define PIPE_CSADD_OVF_EN to add the registered signed-overflow output ovf.
module pipe_csadd_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    logic [SEG:0] r0, r1;

    // both carry-in cases are formed up front; ci only drives the final mux
    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    assign s  = ci ? r1[SEG-1:0] : r0[SEG-1:0];
    assign co = ci ? r1[SEG]     : r0[SEG];
endmodule

module pipe_csadd #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_CSADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSEG = WIDTH / SEG;

    logic [NSEG-1:0]            vld_pipe;
    logic [NSEG-1:0]            rdy;
    logic [NSEG-1:0][WIDTH-1:0] a_r, b_r, s_r;
    logic [NSEG-1:0]            c_r;

    logic [WIDTH-1:0] a_in [NSEG];
    logic [WIDTH-1:0] b_in [NSEG];
    logic [WIDTH-1:0] s_nx [NSEG];
    logic             c_in [NSEG];
    logic             v_in [NSEG];
    logic [SEG-1:0]   seg_s [NSEG];
    logic             seg_c [NSEG];

    // stage 0 takes the issue-time operand transform; later stages take the previous registers
    always_comb begin
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub | cin;
        v_in[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            a_in[k] = a_r[k-1];
            b_in[k] = b_r[k-1];
            c_in[k] = c_r[k-1];
            v_in[k] = vld_pipe[k-1];
        end
    end

    // a stage can take a beat if it or anything downstream of it has a free slot
    always_comb begin
        logic full;
        for (int k = 0; k < NSEG; k++) begin
            full = 1'b1;
            for (int j = k; j < NSEG; j++) full = full & vld_pipe[j];
            rdy[k] = out_ready | ~full;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NSEG; g++) begin : g_seg
            pipe_csadd_seg #(.SEG(SEG)) u_seg (
                .a  (a_in[g][g*SEG +: SEG]),
                .b  (b_in[g][g*SEG +: SEG]),
                .ci (c_in[g]),
                .s  (seg_s[g]),
                .co (seg_c[g])
            );
        end
    endgenerate

    always_comb begin
        s_nx[0] = '0;
        for (int k = 1; k < NSEG; k++) s_nx[k] = s_r[k-1];
        for (int k = 0; k < NSEG; k++) s_nx[k][k*SEG +: SEG] = seg_s[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= '0;
            c_r      <= '0;
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (rdy[k]) begin
                    vld_pipe[k] <= v_in[k];
                    // data only moves with a real beat, so an emptied stage keeps its last value
                    if (v_in[k]) begin
                        a_r[k] <= a_in[k];
                        b_r[k] <= b_in[k];
                        s_r[k] <= s_nx[k];
                        c_r[k] <= seg_c[k];
                    end
                end
            end
        end
    end

`ifdef PIPE_CSADD_OVF_EN
    logic ovf_r;
    logic cmsb;

    // carry into the MSB recovered from the MSB's own sum bit
    assign cmsb = a_in[NSEG-1][WIDTH-1] ^ b_in[NSEG-1][WIDTH-1] ^ seg_s[NSEG-1][SEG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               ovf_r <= 1'b0;
        else if (rdy[NSEG-1] && v_in[NSEG-1])  ovf_r <= cmsb ^ seg_c[NSEG-1];
    end
    assign ovf = ovf_r;
`endif

    logic unused_tail;
    assign unused_tail = ^{a_r[NSEG-1], b_r[NSEG-1]};

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[NSEG-1];
    assign sum       = s_r[NSEG-1];
    assign cout      = c_r[NSEG-1];
endmodule

// File: tb/tb_pipe_csadd.sv
// Directed + random checks of pipe_csadd against an arithmetic reference queue.
module tb_pipe_csadd;
    localparam int W    = 32;
    localparam int NSEG = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_CSADD_OVF_EN
    logic         ovf;
`endif

    pipe_csadd #(.WIDTH(W), .SEG(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_CSADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    exp_t         q[$];
    int           tests = 0, fails = 0, cyc = 0;
    bit           exact = 1'b0, acc = 1'b0, stall_prev = 1'b0;
    logic [W-1:0] hs;
    logic         hc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: plain modular arithmetic, borrow as a compare
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb);
        exp_t e;
        logic [W:0] t;
        if (sb) begin
            e.s = av - bv;
            e.c = (av >= bv);
        end else begin
            t   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
            e.s = t[W-1:0];
            e.c = t[W];
        end
        e.o = sb ? (av[W-1] != bv[W-1] && e.s[W-1] != av[W-1])
                 : (av[W-1] == bv[W-1] && e.s[W-1] != av[W-1]);
        e.t = cyc;
        return e;
    endfunction

    task automatic put(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
        in_valid = v; a = av; b = bv; cin = ci; sub = sb;
    endtask

    // called at a negedge with inputs set; evaluates both handshakes, then advances one cycle
    task automatic tick();
        exp_t e;
        #1;
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, hs);
            chk("hold_cout", cout, hc);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
`ifdef PIPE_CSADD_OVF_EN
                chk("ovf", ovf, e.o);
`endif
                if (exact) chk("latency", cyc - e.t, NSEG);
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(a, b, cin, sub));
        stall_prev = out_valid && !out_ready;
        hs = sum;
        hc = cout;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && q.size() != 0; n++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int idx;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // wrap-around add, exact latency
        exact = 1'b1;
        out_ready = 1'b1;
        put(1, 32'hFFFF_FFFF, 32'h1, 0, 0);
        tick();
        drain();

        // subtract both ways; cin must be ignored
        put(1, 32'd5, 32'd7, 1, 1); tick();
        put(1, 32'd7, 32'd5, 0, 1); tick();
        drain();

        // back-to-back stream at full throughput
        for (int i = 0; i < 16; i++) begin
            put(1, W'(i), W'(i) << 8, 0, 0);
            tick();
            chk("stream_accept", acc, 1);
        end
        drain();

        // backpressure: pipeline fills at NSEG beats
        exact = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            put(1, W'(idx * 3 + 1), W'(idx * 1000), 0, 0);
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1 chk("bp_ready_comb", in_ready, 1);
        for (int n = 0; n < 20 && idx < 6; n++) begin
            put(1, W'(idx * 3 + 1), W'(idx * 1000), 0, 0);
            tick();
            if (acc) idx++;
        end
        chk("bp_all_sent", idx, 6);
        drain();

        // asynchronous reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1, W'(32'h1111 * (i + 1)), W'(32'h2222), 0, 0);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sum", sum, 0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_quiet", out_valid, 0);
        end

`ifdef PIPE_CSADD_OVF_EN
        put(1, 32'h7FFF_FFFF, 32'h1, 0, 0); tick();
        put(1, 32'h8000_0000, 32'h1, 0, 1); tick();
        drain();
`endif

        // random traffic with random stalls
        for (int i = 0; i < 400; i++) begin
            put(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
